// File: rtl/dmem_line_responder.sv
// ---------------------------------------------------------------------------
// dmem_line_responder
//
// Simple data-memory responder for a cache. A request is accepted only in
// IDLE; after LATENCY wait cycles the access is performed and a one-cycle
// completion pulse is raised. Reads return a full 64-bit line (two aligned
// 32-bit words); writes store a single word.
//
// Parameters:
//   LATENCY  wait cycles before the access (1..255)
//   DEPTH    storage size in 32-bit words (power of two, even)
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   req_valid  cache requests an access
//   req_we     1 = word write, 0 = line read
//   req_addr   byte address, word index = req_addr[31:2], [1:0] ignored
//   req_wdata  write data
//   req_ready  high only in IDLE
//   resp_valid one-cycle completion pulse
//   resp_line  last read line {word1, word0}, held until the next read
//   busy       high in WAIT or RESP
//   resp_err   (DMEM_RESP_ERR_EN only) out-of-range access, valid with
//              resp_valid
//
// Build option: define DMEM_RESP_ERR_EN to flag word indices >= DEPTH as
// errors (write suppressed, line reads as zero). Without it the word index
// wraps modulo DEPTH.
//
// States:
//   state  | meaning
//   IDLE   | ready for a request
//   WAIT   | counting down the access latency
//   RESP   | access done, resp_valid pulse
// ---------------------------------------------------------------------------
module dmem_line_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_line,
  output logic        busy
`ifdef DMEM_RESP_ERR_EN
  ,
  output logic        resp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [63:0]        line_q, line_d;
  logic               access;
  logic               mem_we;
  logic               txn_bad;
  logic [IDX_W-1:0]   base0, base1;
  logic               unused_addr;

  logic [31:0]        mem_q [DEPTH];

`ifdef DMEM_RESP_ERR_EN
  logic               bad_q, bad_d;
  logic               err_q, err_d;

  assign txn_bad     = bad_q;
  assign resp_err    = err_q;
  assign unused_addr = ^req_addr[1:0];
`else
  assign txn_bad     = 1'b0;
  // Upper index bits are dropped, giving the modulo-DEPTH wrap.
  assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

  // The access fires on the last WAIT cycle; RESP follows one edge later.
  assign access = (state_q == S_WAIT) && (cnt_q == 8'd0);
  assign mem_we = access && we_q && !txn_bad;

  // A line is the aligned word pair containing the addressed word.
  assign base0 = {idx_q[IDX_W-1:1], 1'b0};
  assign base1 = {idx_q[IDX_W-1:1], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    line_d  = line_q;
`ifdef DMEM_RESP_ERR_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 8'(LATENCY - 1);
          we_d    = req_we;
          idx_d   = req_addr[IDX_W+1:2];
          wdata_d = req_wdata;
`ifdef DMEM_RESP_ERR_EN
          bad_d   = |req_addr[31:IDX_W+2];
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (access) begin
      if (!we_q) begin
        line_d = txn_bad ? 64'd0 : {mem_q[base1], mem_q[base0]};
      end
`ifdef DMEM_RESP_ERR_EN
      err_d = txn_bad;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      line_q  <= 64'd0;
`ifdef DMEM_RESP_ERR_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
`ifdef DMEM_RESP_ERR_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  // Storage is not reset; an async reset forces IDLE, so a write that was
  // still waiting can never reach this enable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_line  = line_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  localparam int LAT0  = 4;
  localparam int LAT1  = 1;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        sel;

  logic        v0, v1;
  logic        rdy0, rv0, busy0, rdy1, rv1, busy1;
  logic [63:0] line0, line1;
  logic        err0, err1;

  logic        rdy, rv, bsy, err;
  logic [63:0] line;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word arrays per instance and the last read line.
  logic [31:0] model [2][DEPTH];
  logic [63:0] mline [2];

  always #5 clk = ~clk;

  assign v0 = req_valid & ~sel;
  assign v1 = req_valid & sel;

  dmem_line_responder #(.LATENCY(LAT0), .DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy0),
    .resp_valid(rv0), .resp_line(line0), .busy(busy0)
`ifdef DMEM_RESP_ERR_EN
    , .resp_err(err0)
`endif
  );

  dmem_line_responder #(.LATENCY(LAT1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy1),
    .resp_valid(rv1), .resp_line(line1), .busy(busy1)
`ifdef DMEM_RESP_ERR_EN
    , .resp_err(err1)
`endif
  );

`ifndef DMEM_RESP_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  assign rdy  = sel ? rdy1  : rdy0;
  assign rv   = sel ? rv1   : rv0;
  assign bsy  = sel ? busy1 : busy0;
  assign line = sel ? line1 : line0;
  assign err  = sel ? err1  : err0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the selected instance. drop=0 leaves
  // req_valid high afterwards so the next call can test back-to-back accept.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit drop);
    int   k;
    int   idx;
    int   s;
    int   lat;
    bit   bad;
    s   = sel ? 1 : 0;
    lat = sel ? LAT1 : LAT0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (rdy !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("ready_before_accept", {63'd0, rdy}, 64'd1);
    @(posedge clk); #1;
    if (drop) req_valid = 1'b0;
    // Inputs change while busy; the latched request must be unaffected.
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("busy_after_accept", {62'd0, bsy, rdy}, 64'd2);
    k = 0;
    while (rv !== 1'b1 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    // Seen high after edge LAT, so captured on edge LAT+1 after accept.
    chk("resp_latency", 64'(k), 64'(lat));

    idx = int'(addr[31:2]);
    bad = 1'b0;
`ifdef DMEM_RESP_ERR_EN
    bad = (idx >= DEPTH);
`else
    idx = idx % DEPTH;
`endif
    if (!bad) begin
      if (we) model[s][idx] = wdata;
      else    mline[s] = {model[s][idx | 1], model[s][idx & ~1]};
    end else if (!we) begin
      mline[s] = 64'd0;
    end
    chk("resp_line", line, mline[s]);
    chk("busy_in_resp", {63'd0, bsy}, 64'd1);
`ifdef DMEM_RESP_ERR_EN
    chk("resp_err", {63'd0, err}, {63'd0, bad});
`endif
    @(posedge clk); #1;
    chk("pulse_one_cycle", {63'd0, rv}, 64'd0);
    chk("ready_after_resp", {63'd0, rdy}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    sel       = 1'b0;
    mline[0]  = 64'd0;
    mline[1]  = 64'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {63'd0, rv0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_line0", line0, 64'd0);
    chk("rst_line1", line1, 64'd0);
    chk("rst_err", {63'd0, err0}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {63'd0, rdy0}, 64'd1);

    // Fill both instances so every word has a known value.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1);
    end
    sel = 1'b0;

    // Write then read the same line; containing line returned.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    chk("req028_low_word", {32'd0, line[31:0]}, 64'h0000_0000_DEAD_BEEF);

    // Misaligned word read returns the aligned line; byte offset ignored.
    issue(1'b1, 32'h10, 32'h11111111, 1'b1);
    issue(1'b1, 32'h14, 32'h22222222, 1'b1);
    issue(1'b0, 32'h14, 32'h0, 1'b1);
    chk("req029_line", line, 64'h22222222_11111111);
    issue(1'b0, 32'h13, 32'h0, 1'b1);
    chk("byte_offset_ignored", line, 64'h22222222_11111111);

    // Line holds across a following write.
    issue(1'b1, 32'h80, 32'hA5A5A5A5, 1'b1);
    chk("line_held_after_write", line, 64'h22222222_11111111);

    // req_valid held: second accept on the cycle after RESP.
    issue(1'b0, 32'h40, 32'h0, 1'b0);
    issue(1'b0, 32'h48, 32'h0, 1'b1);

    // Reset during the WAIT of a write aborts it.
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_busy_before_rst", {63'd0, busy0}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy0}, 64'd0);
    chk("abort_ready", {63'd0, rdy0}, 64'd1);
    chk("abort_line_cleared", line0, 64'd0);
    mline[0] = 64'd0;
    mline[1] = 64'd0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (LAT0 + 4) begin
      @(posedge clk); #1;
      if (rv0 === 1'b1) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    issue(1'b0, 32'h20, 32'h0, 1'b1);

    // Index DEPTH: aliases to line 0, or errors with the option enabled.
    issue(1'b0, 32'h400, 32'h0, 1'b1);
`ifdef DMEM_RESP_ERR_EN
    chk("oor_read_zero", line, 64'd0);
`else
    chk("alias_read", line, {model[0][1], model[0][0]});
`endif
    issue(1'b1, 32'h404, 32'h5EED0001, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 1'b1);

    // LATENCY=1 instance: 2-cycle accept-to-capture.
    sel = 1'b1;
    issue(1'b1, 32'h30, 32'h0BADF00D, 1'b1);
    issue(1'b0, 32'h34, 32'h0, 1'b1);
    issue(1'b0, 32'h30, 32'h0, 1'b0);
    issue(1'b0, 32'h38, 32'h0, 1'b1);

    // Randomized mix over both instances, including out-of-range indices.
    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom);
      issue(1'($urandom), $urandom_range(0, DEPTH * 8 - 1), $urandom,
            (i == 59) ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_line_responder.md
DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the number of WAIT-state cycles before access (legal range 1..255).
REQ-002 Parameter DEPTH, default 256, SHALL set the storage size in 32-bit words (power of two, even).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  cache requests an access.
REQ-006 req_we  input  1  1 = word write, 0 = line read.
REQ-007 req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  high only in IDLE; request is accepted when req_valid && req_ready.
REQ-010 resp_valid  output  1  one-cycle completion pulse (countdone equivalent).
REQ-011 resp_line  output  64  read line {word1, word0}.
REQ-012 busy  output  1  high in WAIT or RESP.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 IDLE: on accept, latch addr/we/wdata, load counter = LATENCY-1, go to WAIT; otherwise stay.
REQ-015 Requests presented while not IDLE SHALL be ignored (no queuing); the cache holds req_valid until accepted.
REQ-016 WAIT: counter decrements each cycle; when counter == 0, perform access and go to RESP.
REQ-017 Read access: line base = word index with bit 0 cleared; resp_line = {mem[base+1], mem[base]}; word-level misalignment (addr[2]=1) SHALL return the containing aligned line.
REQ-018 Write access: mem[word index] = latched wdata; resp_line unchanged.
REQ-019 RESP: resp_valid = 1 for exactly one cycle, then return to IDLE.
REQ-020 Latency from accept edge to resp_valid high SHALL be LATENCY+1 cycles; back-to-back accept is possible on the cycle after RESP.
REQ-021 resp_line SHALL hold its value until the next read completes.
REQ-022 A read following a write to the same line SHALL return the new data.
REQ-023 addr[1:0] SHALL be ignored.

Reset
REQ-024 When rst is low: state = IDLE, counter = 0, resp_valid = 0, resp_line = 0, busy = 0, req_ready = 1 after release.
REQ-025 Reset mid-operation SHALL abort the transaction; a pending write SHALL NOT be committed; storage contents are not cleared.

Configuration
REQ-026 Macro DMEM_RESP_ERR_EN defined: adds output resp_err (1 bit, reset 0) that is valid with resp_valid; word index >= DEPTH -> write suppressed, resp_line = 0, resp_err = 1.
REQ-027 Macro DMEM_RESP_ERR_EN undefined: no resp_err port; word index is taken modulo DEPTH (upper bits dropped); all accesses complete normally.

Verification (LATENCY=4, DEPTH=256)
REQ-028 Write 0xDEADBEEF @0x10, then read @0x10 -> resp_valid 5 cycles after each accept; resp_line = {mem[5], 0xDEADBEEF}.
REQ-029 Read @0x14 after writes 0x11111111 @0x10 and 0x22222222 @0x14 -> resp_line = 0x22222222_11111111.
REQ-030 req_valid held high continuously for reads -> accept, 5-cycle gap, one resp_valid pulse, req_ready high again the cycle after RESP; no extra pulses.
REQ-031 rst low during WAIT of write 0xCAFEF00D @0x20 -> no resp_valid; subsequent read @0x20 returns the prior value.
REQ-032 Address 0x400 (index 256): macro undefined -> aliases to index 0 (read returns mem[1:0]); macro defined -> resp_err = 1, resp_line = 0, no write.
REQ-033 LATENCY=1 build: accept -> resp_valid exactly 2 cycles later.
